// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: decoder instruction IDs, forward selects, hazard FSM states
// and the in-flight scoreboard slot layout.
package pipeline_pkg;

    localparam logic [5:0] ID_ADD        = 6'd0;
    localparam logic [5:0] ID_ADDI       = 6'd10;
    localparam logic [5:0] ID_LB         = 6'd19;
    localparam logic [5:0] ID_SB         = 6'd24;
    localparam logic [5:0] ID_BEQ        = 6'd27;
    localparam logic [5:0] ID_JAL        = 6'd33;
    localparam logic [5:0] ID_JALR       = 6'd34;
    localparam logic [5:0] ID_LUI        = 6'd35;
    localparam logic [5:0] ID_AUIPC      = 6'd36;
    localparam logic [5:0] ID_LAST_LEGAL = 6'd36;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StTrap  = 2'd2
    } hs_state_e;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic wr;
        logic is_load;
        logic illegal;
    } instr_class_t;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [4:0] rd;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
    } slot_t;

    // A load still in MEM has no data yet, so only non-load MEM results may be forwarded.
    function automatic logic [1:0] fwd_select(input logic used, input logic [4:0] rs,
                                              input slot_t mem, input slot_t wb);
        logic [1:0] sel;
        sel = FWD_RF;
        if (used && rs != 5'd0) begin
            if (mem.valid && mem.wr && !mem.is_load && mem.rd == rs) begin
                sel = FWD_MEM;
            end else if (wb.valid && wb.wr && wb.rd == rs) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// Decode-side handshake between the ID stage and the hazard scheduler.
interface hazard_scheduler_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             id_valid;
    logic [5:0]       id_instr;
    logic [4:0]       id_rd;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             ex_redirect;
    logic             trap_ack;
    logic             stall_fetch;
    logic             flush;
    logic             issue_valid;
    logic [1:0]       ex_fwd_rs1;
    logic [1:0]       ex_fwd_rs2;
    logic             trap_req;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_instr, id_rd, id_rs1, id_rs2, ex_redirect, trap_ack,
        input  stall_fetch, flush, issue_valid, ex_fwd_rs1, ex_fwd_rs2, trap_req, stall_count
    );

    modport slave (
        input  id_valid, id_instr, id_rd, id_rs1, id_rs2, ex_redirect, trap_ack,
        output stall_fetch, flush, issue_valid, ex_fwd_rs1, ex_fwd_rs2, trap_req, stall_count
    );
endinterface

// File: rtl/instr_class_decode.sv
// Maps a 6-bit decoder instruction ID to its operand usage, write-back and load flags.
module instr_class_decode
    import pipeline_pkg::*;
(
    input  logic [5:0]   instr_id,
    output instr_class_t instr_cls
);

    always_comb begin
        instr_cls = '0;
        case (instr_id) inside
            [ID_ADD : ID_ADDI - 6'd1]: begin
                instr_cls.use_rs1 = 1'b1;
                instr_cls.use_rs2 = 1'b1;
                instr_cls.wr      = 1'b1;
            end
            [ID_ADDI : ID_LB - 6'd1]: begin
                instr_cls.use_rs1 = 1'b1;
                instr_cls.wr      = 1'b1;
            end
            [ID_LB : ID_SB - 6'd1]: begin
                instr_cls.use_rs1 = 1'b1;
                instr_cls.wr      = 1'b1;
                instr_cls.is_load = 1'b1;
            end
            [ID_SB : ID_JAL - 6'd1]: begin
                // Stores and branches read both sources and write nothing.
                instr_cls.use_rs1 = 1'b1;
                instr_cls.use_rs2 = 1'b1;
            end
            ID_JAL: instr_cls.wr = 1'b1;
            ID_JALR: begin
                instr_cls.use_rs1 = 1'b1;
                instr_cls.wr      = 1'b1;
            end
            [ID_LUI : ID_AUIPC]: instr_cls.wr = 1'b1;
            default: instr_cls.illegal = (instr_id > ID_LAST_LEGAL);
        endcase
    end

endmodule

// File: rtl/hazard_scheduler.sv
// ID-stage hazard controller: load-use stalls, EX forwarding selects, and drain-then-trap
// handling of illegal instructions, backed by an EX/MEM/WB scoreboard.
module hazard_scheduler
    import pipeline_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input logic               clock,
    input logic               reset_n,
    hazard_scheduler_if.slave bus
);

    hs_state_e        state_q, state_d;
    slot_t            ex_q, mem_q, wb_q, ex_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    instr_class_t     id_cls;
    logic             rs1_hit, rs2_hit, load_use;
    logic             stall_fetch, flush, issue_valid;
    logic             unused_wb;

    instr_class_decode u_decode (
        .instr_id  (bus.id_instr),
        .instr_cls (id_cls)
    );

    assign rs1_hit  = id_cls.use_rs1 && (bus.id_rs1 != 5'd0) && (bus.id_rs1 == ex_q.rd);
    assign rs2_hit  = id_cls.use_rs2 && (bus.id_rs2 != 5'd0) && (bus.id_rs2 == ex_q.rd);
    assign load_use = bus.id_valid && ex_q.valid && ex_q.is_load && ex_q.wr && (rs1_hit || rs2_hit);

    always_comb begin
        stall_fetch = 1'b0;
        flush       = 1'b0;
        issue_valid = 1'b0;
        state_d     = state_q;
        unique case (state_q)
            StRun: begin
                if (bus.ex_redirect) begin
                    flush = 1'b1;
                end else if (load_use) begin
                    stall_fetch = 1'b1;
                end else if (bus.id_valid && id_cls.illegal) begin
                    stall_fetch = 1'b1;
                    state_d     = StDrain;
                end else begin
                    issue_valid = bus.id_valid;
                end
            end
            StDrain: begin
                // A redirect means the illegal instruction was on the wrong path.
                if (bus.ex_redirect) begin
                    flush   = 1'b1;
                    state_d = StRun;
                end else begin
                    stall_fetch = 1'b1;
                    if (!ex_q.valid && !mem_q.valid && !wb_q.valid) begin
                        state_d = StTrap;
                    end
                end
            end
            StTrap: begin
                stall_fetch = 1'b1;
                if (bus.trap_ack) begin
                    flush   = 1'b1;
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        ex_d         = '0;
        ex_d.valid   = issue_valid;
        ex_d.wr      = id_cls.wr && (bus.id_rd != 5'd0);
        ex_d.rd      = bus.id_rd;
        ex_d.is_load = id_cls.is_load;
        ex_d.rs1     = bus.id_rs1;
        ex_d.rs2     = bus.id_rs2;
        ex_d.use_rs1 = id_cls.use_rs1;
        ex_d.use_rs2 = id_cls.use_rs2;
    end

    assign stall_count_d = (stall_fetch && stall_count_q != {CNT_W{1'b1}}) ?
                           stall_count_q + 1'b1 : stall_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StRun;
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ex_q          <= ex_d;
            mem_q         <= ex_q;
            wb_q          <= mem_q;
            stall_count_q <= stall_count_d;
        end
    end

    assign unused_wb = ^{wb_q.is_load, wb_q.rs1, wb_q.rs2, wb_q.use_rs1, wb_q.use_rs2};

    assign bus.stall_fetch = stall_fetch;
    assign bus.flush       = flush;
    assign bus.issue_valid = issue_valid;
    assign bus.ex_fwd_rs1  = fwd_select(ex_q.valid && ex_q.use_rs1, ex_q.rs1, mem_q, wb_q);
    assign bus.ex_fwd_rs2  = fwd_select(ex_q.valid && ex_q.use_rs2, ex_q.rs2, mem_q, wb_q);
    assign bus.trap_req    = (state_q == StTrap);
    assign bus.stall_count = stall_count_q;

endmodule
